// File: rtl/nx_fifo_rd_stage.sv
// Two-entry read stage (head + skid) that pops an upstream nx_fifo and presents registered data downstream.
// Optional NX_FIFO_RD_STAGE_STATS_EN adds a 32-bit xfer_cnt output counting accepted transfers.
module nx_fifo_rd_stage #(
  parameter int WIDTH      = 106,
  parameter int DATA_RESET = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_rdata,
  output logic             fifo_ren,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occ
`ifdef NX_FIFO_RD_STAGE_STATS_EN
  ,
  output logic [31:0]      xfer_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_valid;
  logic [WIDTH-1:0] r_head;
  logic [WIDTH-1:0] r_skid;

  logic w_push;
  logic w_pop;

  // Pop request depends only on registered occupancy, never on out_ready.
  assign w_push    = !fifo_empty && !clear && !rst && (r_state != TWO);
  assign w_pop     = r_valid && out_ready;
  assign fifo_ren  = w_push;
  assign out_valid = r_valid;
  assign out_data  = r_head;
  assign occ       = r_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= EMPTY;
      r_valid <= 1'b0;
      if (DATA_RESET != 0) begin
        r_head <= '0;
        r_skid <= '0;
      end
    end else if (clear) begin
      r_state <= EMPTY;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_push) begin
            r_head  <= fifo_rdata;
            r_state <= ONE;
            r_valid <= 1'b1;
          end
        end
        ONE: begin
          if (w_push && w_pop) begin
            r_head <= fifo_rdata;
          end else if (w_push) begin
            r_skid  <= fifo_rdata;
            r_state <= TWO;
          end else if (w_pop) begin
            r_state <= EMPTY;
            r_valid <= 1'b0;
          end
        end
        TWO: begin
          if (w_pop) begin
            r_head  <= r_skid;
            r_state <= ONE;
          end
        end
        default: begin
          r_state <= EMPTY;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef NX_FIFO_RD_STAGE_STATS_EN
  logic [31:0] r_xfer_cnt;

  // Handshakes in a clear cycle still count as delivered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_xfer_cnt <= '0;
    end else if (w_pop) begin
      r_xfer_cnt <= r_xfer_cnt + 32'd1;
    end
  end

  assign xfer_cnt = r_xfer_cnt;
`endif

endmodule

// File: tb/tb_nx_fifo_rd_stage.sv
// Directed self-checking bench for nx_fifo_rd_stage; a bench-side array models the upstream FIFO.
// Counter checks are compiled in when NX_FIFO_RD_STAGE_STATS_EN is defined.
module tb_nx_fifo_rd_stage;

  localparam int WIDTH = 106;

  logic             clk = 1'b0;
  logic             rst;
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_rdata;
  logic             fifo_ren;
  logic             clear;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       occ;
`ifdef NX_FIFO_RD_STAGE_STATS_EN
  logic [31:0]      xfer_cnt;
`endif

  logic [WIDTH-1:0] src [32];
  int               src_len = 0;
  int               rd_ptr  = 0;
  int               n_chk   = 0;
  int               n_fail  = 0;

  always #5 clk = ~clk;

  assign fifo_empty = (rd_ptr >= src_len);
  assign fifo_rdata = (rd_ptr < 32) ? src[rd_ptr] : '0;

  always @(posedge clk) begin
    if (fifo_ren) rd_ptr <= rd_ptr + 1;
  end

  nx_fifo_rd_stage #(
    .WIDTH      (WIDTH),
    .DATA_RESET (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_rdata (fifo_rdata),
    .fifo_ren   (fifo_ren),
    .clear      (clear),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .occ        (occ)
`ifdef NX_FIFO_RD_STAGE_STATS_EN
    ,
    .xfer_cnt   (xfer_cnt)
`endif
  );

  function automatic logic [WIDTH-1:0] mk(input int k);
    logic [WIDTH-1:0] v;
    v = '0;
    v[WIDTH-1 -: 16] = 16'(k) ^ 16'hA5A5;
    v[31:0]          = 32'(k) * 32'h9E3779B9;
    v[63:48]         = 16'(k);
    return v;
  endfunction

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add_src(input int k);
    src[src_len] = mk(k);
    src_len++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 32; i++) src[i] = '0;
    rst = 1'b1; clear = 1'b0; out_ready = 1'b0;
    tick(); tick();
    chk("rst_occ",   occ, 2'd0);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_data",  out_data, '0);
    chk("rst_ren",   fifo_ren, 1'b0);

    // Upstream empty after reset
    rst = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("empty_ren",   fifo_ren, 1'b0);
      chk("empty_valid", out_valid, 1'b0);
      chk("empty_occ",   occ, 2'd0);
    end

    // A, B, C stream with out_ready held high
    rst = 1'b1;
    add_src(1); add_src(2); add_src(3);
    tick();
    #1 chk("ren_in_rst", fifo_ren, 1'b0);
    rst = 1'b0;
    #1 chk("ren_first", fifo_ren, 1'b1);
    tick();
    chk("s_valid_a", out_valid, 1'b1);
    chk("s_data_a",  out_data, mk(1));
    chk("s_ren_b",   fifo_ren, 1'b1);
    tick();
    chk("s_data_b",  out_data, mk(2));
    chk("s_ren_c",   fifo_ren, 1'b1);
    tick();
    chk("s_data_c",  out_data, mk(3));
    chk("s_valid_c", out_valid, 1'b1);
    chk("s_ren_end", fifo_ren, 1'b0);
    tick();
    chk("s_valid_0", out_valid, 1'b0);
    chk("s_occ_0",   occ, 2'd0);

    // Backpressure fills head and skid, then drains in order
    out_ready = 1'b0;
    add_src(4); add_src(5); add_src(6);
    tick(); tick();
    chk("bp_occ2",  occ, 2'd2);
    chk("bp_ren0",  fifo_ren, 1'b0);
    chk("bp_data",  out_data, mk(4));
    chk("bp_pops",  rd_ptr, 5);
    tick();
    chk("bp_hold_occ",  occ, 2'd2);
    chk("bp_hold_data", out_data, mk(4));
    chk("bp_hold_pops", rd_ptr, 5);
    out_ready = 1'b1;
    tick();
    chk("bp_data_b", out_data, mk(5));
    chk("bp_occ1",   occ, 2'd1);
    tick();
    chk("bp_data_c", out_data, mk(6));
    chk("bp_valid",  out_valid, 1'b1);
    tick();
    chk("bp_drain",  out_valid, 1'b0);
    chk("bp_pops_all", rd_ptr, 6);

    // Clear while full with out_ready low
    out_ready = 1'b0;
    add_src(7); add_src(8);
    tick(); tick();
    chk("clr_pre_occ", occ, 2'd2);
    add_src(9);
    clear = 1'b1;
    #1 chk("clr_ren", fifo_ren, 1'b0);
    tick();
    chk("clr_occ",   occ, 2'd0);
    chk("clr_valid", out_valid, 1'b0);
    chk("clr_ptr",   rd_ptr, 8);
    clear = 1'b0; out_ready = 1'b1;
    tick();
    chk("clr_after_data",  out_data, mk(9));
    chk("clr_after_valid", out_valid, 1'b1);
    tick();
    chk("clr_after_drain", out_valid, 1'b0);

    // Reset while full
    out_ready = 1'b0;
    add_src(10); add_src(11); add_src(12);
    tick(); tick();
    chk("mrst_pre_occ", occ, 2'd2);
    rst = 1'b1;
    #1 chk("mrst_ren", fifo_ren, 1'b0);
    tick();
    chk("mrst_occ",   occ, 2'd0);
    chk("mrst_valid", out_valid, 1'b0);
    chk("mrst_data",  out_data, '0);
    chk("mrst_ren2",  fifo_ren, 1'b0);
    rst = 1'b0;
    #1 chk("mrst_ren_rel", fifo_ren, 1'b1);
    out_ready = 1'b1;
    tick();
    chk("mrst_data_i", out_data, mk(12));
    tick();
    chk("mrst_drain", out_valid, 1'b0);

`ifdef NX_FIFO_RD_STAGE_STATS_EN
    rst = 1'b1;
    tick();
    chk("cnt_rst", xfer_cnt, 32'd0);
    rst = 1'b0;
    for (int k = 13; k < 18; k++) add_src(k);
    begin
      logic [9:0] rdy_pat;
      rdy_pat = 10'b1111010101;
      for (int i = 0; i < 10; i++) begin
        out_ready = rdy_pat[i];
        tick();
      end
    end
    out_ready = 1'b0;
    tick(); tick();
    chk("cnt_five",  xfer_cnt, 32'd5);
    chk("cnt_empty", occ, 2'd0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("cnt_clr", xfer_cnt, 32'd5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("cnt_rst2", xfer_cnt, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
